// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, instruction-cache address split, frame layout and FSM states.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned ITAG_W = 26;
    localparam int unsigned IIDX_W = 4;
    localparam int unsigned IBYT_W = 2;
    localparam int unsigned ISETS  = 1 << IIDX_W;

    typedef logic [WORD_W-1:0] word_t;

    // Byte address as seen by the instruction cache.
    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [IBYT_W-1:0] bytoff;
    } icachef_t;

    // Tag and data part of a frame; valid bits are kept separately so they alone are reset.
    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        word_t             data;
    } icache_frame_t;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } icache_state_t;

endpackage

// File: rtl/caches_if.sv
// Cache interface: datapath side (icache modport) and memory-controller side (cif modport).
interface caches_if;
    import cpu_types_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;

    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    modport icache (
        input  imemREN, imemaddr,
        output ihit, imemload
    );

    modport cif (
        output iREN, iaddr,
        input  iwait, iload
    );

endinterface

// File: rtl/icache.sv
// Direct-mapped 16-frame instruction cache, one word per block; fills are always served
// from the frame array on the cycle after the fill edge.
module icache
    import cpu_types_pkg::*;
(
    input  logic      CLK,
    input  logic      nRST,
    caches_if.icache  dcif,
    caches_if.cif     cif
);

    icache_state_t          state, next_state;
    logic [ISETS-1:0]       valid_q;
    icache_frame_t          frames [ISETS];

    icachef_t               faddr;
    logic                   hit;
    logic                   fill;
    logic                   ren_c;
    word_t                  raddr_c;
    logic                   unused_bytoff;

    assign faddr         = icachef_t'(dcif.imemaddr);
    assign unused_bytoff = ^faddr.bytoff;

    // Zero-latency lookup, independent of FSM state.
    assign hit           = dcif.imemREN & valid_q[faddr.idx] & (frames[faddr.idx].tag == faddr.tag);
    assign dcif.ihit     = hit;
    assign dcif.imemload = hit ? frames[faddr.idx].data : '0;

    assign cif.iREN      = ren_c;
    assign cif.iaddr     = raddr_c;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ren_c      = 1'b0;
        raddr_c    = '0;
        fill       = 1'b0;
        unique case (state)
            IDLE: begin
                if (dcif.imemREN && !hit) begin
                    next_state = MISS;
                end
            end
            MISS: begin
                // The request stays up even if the datapath drops imemREN; address tracks imemaddr.
                ren_c   = 1'b1;
                raddr_c = dcif.imemaddr;
                if (!cif.iwait) begin
                    fill       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= '0;
        end else if (fill) begin
            valid_q[faddr.idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (fill) begin
            frames[faddr.idx] <= '{tag: faddr.tag, data: cif.iload};
        end
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: a per-cycle vector table plus hand-written reset-mid-miss sequence.
module tb_icache;
    import cpu_types_pkg::*;

    logic CLK;
    logic nRST;
    caches_if ccif ();

    icache dut (
        .CLK  (CLK),
        .nRST (nRST),
        .dcif (ccif),
        .cif  (ccif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic        ren;
        logic [31:0] addr;
        logic        wt;
        logic [31:0] load;
        logic        e_hit;
        logic [31:0] e_load;
        logic        e_iren;
        logic [31:0] e_iaddr;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   failures;

    function automatic vec_t mk(string n, logic r, logic [31:0] a, logic w, logic [31:0] l,
                                logic eh, logic [31:0] el, logic er, logic [31:0] ea);
        vec_t v;
        v.name = n; v.ren = r; v.addr = a; v.wt = w; v.load = l;
        v.e_hit = eh; v.e_load = el; v.e_iren = er; v.e_iaddr = ea;
        return v;
    endfunction

    task automatic check(string n, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", n, got, exp);
        end
    endtask

    task automatic check_outs(string n, logic eh, logic [31:0] el, logic er, logic [31:0] ea);
        check({n, ".ihit"},     32'(ccif.ihit),     32'(eh));
        check({n, ".imemload"}, ccif.imemload,      el);
        check({n, ".iREN"},     32'(ccif.iREN),     32'(er));
        check({n, ".iaddr"},    ccif.iaddr,         ea);
    endtask

    task automatic drive(logic r, logic [31:0] a, logic w, logic [31:0] l);
        ccif.imemREN  = r;
        ccif.imemaddr = a;
        ccif.iwait    = w;
        ccif.iload    = l;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        nRST     = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 32'h0);

        // One entry per clock cycle; expected values are the combinational outputs before that edge.
        vecs.push_back(mk("m4_req",    1, 32'h04, 1, 32'h0,        0, 32'h0,        0, 32'h0));
        vecs.push_back(mk("m4_fill",   1, 32'h04, 0, 32'h8C010000, 0, 32'h0,        1, 32'h04));
        vecs.push_back(mk("h4_a",      1, 32'h04, 1, 32'h0,        1, 32'h8C010000, 0, 32'h0));
        vecs.push_back(mk("h4_b",      1, 32'h04, 1, 32'h0,        1, 32'h8C010000, 0, 32'h0));
        vecs.push_back(mk("m44_req",   1, 32'h44, 1, 32'h0,        0, 32'h0,        0, 32'h0));
        vecs.push_back(mk("m44_fill",  1, 32'h44, 0, 32'hDEADBEEF, 0, 32'h0,        1, 32'h44));
        vecs.push_back(mk("h44",       1, 32'h44, 1, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0));
        vecs.push_back(mk("evict4",    1, 32'h04, 1, 32'h0,        0, 32'h0,        0, 32'h0));
        vecs.push_back(mk("evict4_f",  1, 32'h04, 0, 32'h8C010000, 0, 32'h0,        1, 32'h04));
        vecs.push_back(mk("noren",     0, 32'h04, 1, 32'h0,        0, 32'h0,        0, 32'h0));
        vecs.push_back(mk("m8_req",    1, 32'h08, 1, 32'h0,        0, 32'h0,        0, 32'h0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk("m8_wait", 1, 32'h08, 1, 32'h0,      0, 32'h0,        1, 32'h08));
        vecs.push_back(mk("m8_fill",   1, 32'h08, 0, 32'h12345678, 0, 32'h0,        1, 32'h08));
        vecs.push_back(mk("h8",        1, 32'h08, 1, 32'h0,        1, 32'h12345678, 0, 32'h0));
        vecs.push_back(mk("mC_req",    1, 32'h0C, 1, 32'h0,        0, 32'h0,        0, 32'h0));
        vecs.push_back(mk("mC_drop",   0, 32'h0C, 0, 32'hAAAA5555, 0, 32'h0,        1, 32'h0C));
        vecs.push_back(mk("hC",        1, 32'h0C, 1, 32'h0,        1, 32'hAAAA5555, 0, 32'h0));
        vecs.push_back(mk("m10_req",   1, 32'h10, 1, 32'h0,        0, 32'h0,        0, 32'h0));
        vecs.push_back(mk("mv_fill",   1, 32'h14, 0, 32'h00000055, 0, 32'h0,        1, 32'h14));
        vecs.push_back(mk("h14",       1, 32'h14, 1, 32'h0,        1, 32'h00000055, 0, 32'h0));
        vecs.push_back(mk("m10_cold",  1, 32'h10, 1, 32'h0,        0, 32'h0,        0, 32'h0));
        vecs.push_back(mk("m10_fill",  1, 32'h10, 0, 32'h00000010, 0, 32'h0,        1, 32'h10));
        vecs.push_back(mk("m44_again", 1, 32'h44, 1, 32'h0,        0, 32'h0,        0, 32'h0));
        vecs.push_back(mk("m44_f2",    1, 32'h44, 0, 32'hDEADBEEF, 0, 32'h0,        1, 32'h44));
        vecs.push_back(mk("h44_2",     1, 32'h44, 1, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0));

        repeat (2) @(posedge CLK);
        #1;
        check_outs("reset", 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;

        foreach (vecs[i]) begin
            @(posedge CLK);
            #1;
            drive(vecs[i].ren, vecs[i].addr, vecs[i].wt, vecs[i].load);
            @(negedge CLK);
            check_outs(vecs[i].name, vecs[i].e_hit, vecs[i].e_load, vecs[i].e_iren, vecs[i].e_iaddr);
        end

        // Enter MISS on 0x80, then pulse reset while a fill is pending.
        @(posedge CLK);
        #1;
        drive(1'b1, 32'h80, 1'b1, 32'h0);
        @(posedge CLK);
        #1;
        check_outs("rst_pre", 1'b0, 32'h0, 1'b1, 32'h80);
        drive(1'b1, 32'h80, 1'b0, 32'hBAD0BAD0);
        #1;
        nRST = 1'b0;
        #1;
        check_outs("rst_async", 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge CLK);
        #1;
        check_outs("rst_hold", 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        drive(1'b1, 32'h80, 1'b1, 32'h0);
        #1;
        check_outs("rst_nofill", 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge CLK);
        #1;
        drive(1'b1, 32'h44, 1'b1, 32'h0);
        @(negedge CLK);
        check_outs("rst_m44", 1'b0, 32'h0, 1'b1, 32'h44);
        drive(1'b1, 32'h44, 1'b0, 32'hCAFEF00D);
        @(posedge CLK);
        #1;
        check_outs("rst_h44", 1'b1, 32'hCAFEF00D, 1'b0, 32'h0);
        drive(1'b0, 32'h44, 1'b1, 32'h0);
        #1;
        check_outs("rst_noren", 1'b0, 32'h0, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
